// File: rtl/uart_rx.sv
// uart_rx: 8N1-style UART receiver with mid-bit sampling, valid/ack handshake, framing and overrun flags
//   clk_i       clock
//   rst_i       synchronous reset, active-high
//   Rx          asynchronous serial input, idle high
//   rx_ack_i    consumer took data_o (only while rx_valid_o=1)
//   data_o      last good byte
//   rx_valid_o  data_o holds an unacknowledged byte
//   frame_err_o one-cycle pulse when the stop bit is sampled low
//   overrun_o   sticky: a byte landed on top of an unacknowledged one
//   busy_o      receiver is inside a frame
module uart_rx #(
   parameter int  DW        = 8,
   parameter real CLOCK     = 100e6,
   parameter int  BAUD_RATE = 20000000
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          Rx,
   input  logic          rx_ack_i,
   output logic [DW-1:0] data_o,
   output logic          rx_valid_o,
   output logic          frame_err_o,
   output logic          overrun_o,
   output logic          busy_o
);
   localparam int BAUD_COUNTER = $rtoi(CLOCK / BAUD_RATE);
   localparam int BRW          = $clog2(BAUD_COUNTER + 1);
   localparam int HALF         = BAUD_COUNTER / 2;
   localparam int IW           = (DW > 1) ? $clog2(DW) : 1;
   localparam logic [BRW-1:0] HALF_CNT = BRW'(HALF - 1);
   localparam logic [BRW-1:0] LAST_CNT = BRW'(BAUD_COUNTER - 1);
   localparam logic [IW-1:0]  LAST_BIT = IW'(DW - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t          state_q, state_d;
   logic [1:0]      sync_q;
   logic [BRW-1:0]  bcnt_q, bcnt_d;
   logic [IW-1:0]   bit_idx_q, bit_idx_d;
   logic [DW-1:0]   shift_q, shift_d;
   logic [DW-1:0]   data_q, data_d;
   logic            valid_q, valid_d;
   logic            ferr_q, ferr_d;
   logic            ovr_q, ovr_d;
   logic            rx_s, data_tick, stop_tick, good, bad;

   assign rx_s = sync_q[1];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         sync_q    <= '1;
         bcnt_q    <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         sync_q    <= {sync_q[0], Rx};
         bcnt_q    <= bcnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
         ovr_q     <= ovr_d;
      end
   end

   // START re-checks the line at its mid-point so a short low glitch falls back to IDLE
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (!rx_s) state_d = START;
         START:   if (bcnt_q == HALF_CNT) state_d = rx_s ? IDLE : DATA;
         DATA:    if (bcnt_q == LAST_CNT && bit_idx_q == LAST_BIT) state_d = STOP;
         STOP:    if (bcnt_q == LAST_CNT) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      data_tick = (state_q == DATA) && (bcnt_q == LAST_CNT);
      stop_tick = (state_q == STOP) && (bcnt_q == LAST_CNT);
      good      = stop_tick && rx_s;
      bad       = stop_tick && !rx_s;
      bcnt_d    = (state_q == IDLE || state_d != state_q || data_tick) ? '0 : bcnt_q + 1'b1;
      bit_idx_d = (state_q == START) ? '0 : data_tick ? bit_idx_q + 1'b1 : bit_idx_q;
      shift_d   = data_tick ? {rx_s, shift_q[DW-1:1]} : shift_q;
      data_d    = good ? shift_q : data_q;
      // an ack coinciding with a good stop lets the new byte through without overrun
      valid_d   = good | (valid_q & ~rx_ack_i);
      ovr_d     = ovr_q | (good & valid_q & ~rx_ack_i);
      ferr_d    = bad;
      busy_o    = state_q != IDLE;
   end

   assign data_o      = data_q;
   assign rx_valid_o  = valid_q;
   assign frame_err_o = ferr_q;
   assign overrun_o   = ovr_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx (table vectors, corner sequences, random frames vs. model)
module tb_uart_rx;
   logic       clk_i = 1'b0;
   logic       rst_i = 1'b1;
   logic       Rx = 1'b1;
   logic       rx_ack_i = 1'b0;
   logic [7:0] data_o;
   logic       rx_valid_o, frame_err_o, overrun_o, busy_o;

   uart_rx dut (
      .clk_i(clk_i), .rst_i(rst_i), .Rx(Rx), .rx_ack_i(rx_ack_i),
      .data_o(data_o), .rx_valid_o(rx_valid_o), .frame_err_o(frame_err_o),
      .overrun_o(overrun_o), .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [7:0] b;
      logic       stop;
      int         ack_at;
      int         gap;
      logic [7:0] e_data;
      logic       e_valid;
      logic       e_ferr;
      logic       e_ovr;
   } vec_t;

   int tests = 0, fails = 0;
   int cyc = 0, start_cyc = 0, last_rise = 0, ferr_cycles = 0, exp_ferr = 0;
   logic prev_v = 1'b0;
   logic [7:0] m_data;
   logic m_valid, m_ovr;
   logic [7:0] exp_q[$], got_q[$];
   vec_t tbl[10];

   always @(posedge clk_i) cyc <= cyc + 1;

   // observer: accepted bytes, frame-error cycles and valid rising edges
   always @(negedge clk_i) begin
      #1;
      if (!rst_i) begin
         if (rx_ack_i && rx_valid_o) got_q.push_back(data_o);
         if (frame_err_o) ferr_cycles++;
         if (rx_valid_o && !prev_v) last_rise = cyc;
      end
      prev_v = rx_valid_o;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_data = 8'h00;
      m_valid = 1'b0;
      m_ovr = 1'b0;
   endtask

   task automatic idle(input int n);
      Rx = 1'b1;
      repeat (n) @(negedge clk_i);
   endtask

   // drives one frame at 5 clk/bit starting at the current negedge; ends 50 cycles later
   task automatic send_frame(input logic [7:0] b, input logic stop, input int ack_at);
      logic [9:0] bits;
      bits = {stop, b, 1'b0};
      start_cyc = cyc;
      for (int c = 0; c < 50; c++) begin
         Rx = bits[c / 5];
         rx_ack_i = (c == ack_at);
         if (c == ack_at && m_valid) begin
            exp_q.push_back(m_data);
            m_valid = 1'b0;
         end
         @(negedge clk_i);
         if (c == 25) chk("busy_mid", busy_o, 1);
      end
      rx_ack_i = 1'b0;
      Rx = 1'b1;
      if (stop) begin
         if (m_valid) m_ovr = 1'b1;
         m_data = b;
         m_valid = 1'b1;
      end else exp_ferr++;
   endtask

   initial begin
      tbl[0] = '{8'hAA, 1'b1, -1, 2, 8'hAA, 1'b1, 1'b0, 1'b0};
      tbl[1] = '{8'h55, 1'b1, 10, 0, 8'h55, 1'b1, 1'b0, 1'b0};
      tbl[2] = '{8'h0F, 1'b1, 10, 2, 8'h0F, 1'b1, 1'b0, 1'b0};
      tbl[3] = '{8'h3C, 1'b0, 10, 4, 8'h0F, 1'b0, 1'b1, 1'b0};
      tbl[4] = '{8'hC3, 1'b1, -1, 0, 8'hC3, 1'b1, 1'b0, 1'b0};
      tbl[5] = '{8'h96, 1'b1, 49, 0, 8'h96, 1'b1, 1'b0, 1'b0};
      tbl[6] = '{8'h3C, 1'b0, -1, 4, 8'h96, 1'b1, 1'b1, 1'b0};
      tbl[7] = '{8'h01, 1'b1, -1, 0, 8'h01, 1'b1, 1'b0, 1'b1};
      tbl[8] = '{8'h02, 1'b1, -1, 0, 8'h02, 1'b1, 1'b0, 1'b1};
      tbl[9] = '{8'h7E, 1'b1, 10, 2, 8'h7E, 1'b1, 1'b0, 1'b1};
      model_reset();
      for (int i = 0; i < 3; i++) begin
         Rx = i[0];
         @(negedge clk_i);
      end
      rst_i = 1'b0;
      Rx = 1'b1;
      chk("rst_data", data_o, 0);
      chk("rst_valid", rx_valid_o, 0);
      chk("rst_ferr", frame_err_o, 0);
      chk("rst_ovr", overrun_o, 0);
      chk("rst_busy", busy_o, 0);
      idle(4);
      for (int i = 0; i < 10; i++) begin
         send_frame(tbl[i].b, tbl[i].stop, tbl[i].ack_at);
         chk($sformatf("v%0d_data", i), data_o, tbl[i].e_data);
         chk($sformatf("v%0d_valid", i), rx_valid_o, tbl[i].e_valid);
         chk($sformatf("v%0d_ferr", i), frame_err_o, tbl[i].e_ferr);
         chk($sformatf("v%0d_ovr", i), overrun_o, tbl[i].e_ovr);
         chk($sformatf("v%0d_busy", i), busy_o, 0);
         idle(tbl[i].gap);
         if (i == 0) chk("latency", (last_rise - start_cyc >= 49) && (last_rise - start_cyc <= 51), 1);
      end
      idle(3);
      Rx = 1'b0;
      @(negedge clk_i);
      Rx = 1'b1;
      repeat (2) @(negedge clk_i);
      chk("glitch_busy", busy_o, 1);
      idle(10);
      chk("glitch_idle", busy_o, 0);
      chk("glitch_data", data_o, 8'h7E);
      chk("glitch_valid", rx_valid_o, 1);
      chk("glitch_ovr", overrun_o, 1);
      for (int c = 0; c < 22; c++) begin
         Rx = (c < 5) ? 1'b0 : ((c / 5) % 2 == 0);
         @(negedge clk_i);
      end
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
      model_reset();
      idle(60);
      chk("mid_rst_valid", rx_valid_o, 0);
      chk("mid_rst_data", data_o, 0);
      chk("mid_rst_ovr", overrun_o, 0);
      chk("mid_rst_busy", busy_o, 0);
      send_frame(8'h5A, 1'b1, -1);
      chk("after_rst_data", data_o, 8'h5A);
      chk("after_rst_valid", rx_valid_o, 1);
      idle(3);
      for (int i = 0; i < 40; i++) begin
         logic [7:0] b;
         logic stop;
         int r, ack_at;
         b = 8'($urandom);
         stop = ($urandom_range(0, 7) != 0);
         r = $urandom_range(0, 2);
         ack_at = (r == 0) ? -1 : (r == 1) ? 10 : 49;
         send_frame(b, stop, ack_at);
         chk($sformatf("r%0d_data", i), data_o, m_data);
         chk($sformatf("r%0d_valid", i), rx_valid_o, m_valid);
         chk($sformatf("r%0d_ovr", i), overrun_o, m_ovr);
         chk($sformatf("r%0d_ferr", i), frame_err_o, !stop);
         idle(stop ? $urandom_range(0, 3) : $urandom_range(3, 6));
      end
      idle(4);
      chk("ack_count", got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         chk($sformatf("ack_byte%0d", i), got_q[i], exp_q[i]);
      chk("ferr_cycles", ferr_cycles, exp_ferr);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
